// File: rtl/chb_pkg.sv
// rtl/chb_pkg.sv - shared defaults, width helpers and gate bit indices for the CHB modulator
package chb_pkg;

    localparam int N_CELLS_DEF = 3;
    localparam int CW_DEF      = 12;

    localparam int LEG_A = 0;
    localparam int LEG_B = 1;

    // Signed reference needs room for +/-P and the 2*carrier-P threshold.
    function automatic int ref_width(input int cw);
        return cw + 2;
    endfunction

    function automatic int phase_width(input int cw);
        return cw + 1;
    endfunction

endpackage

// File: rtl/chb_pwm_cell.sv
// rtl/chb_pwm_cell.sv - one H-bridge cell: phase fold, triangle carrier, compare, registered legs
// CHB_SYNC_UPDATE_EN selects valley-synchronous reference latching.
module chb_pwm_cell
    import chb_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CW:0]          i_ph,
    input  logic [CW:0]          i_off,
    input  logic [CW-1:0]        i_p_s,
    input  logic signed [CW+1:0] i_ref_c,
    input  logic                 i_idle,
    output logic [1:0]           o_gate
);

    localparam int PW = phase_width(CW);
    localparam int RW = ref_width(CW);

    logic [PW-1:0]        w_two_p;
    logic [PW-1:0]        w_room;
    logic [PW-1:0]        w_ph_k;
    logic [PW-1:0]        w_carrier;
    logic signed [RW-1:0] w_p_sgn;
    logic signed [RW-1:0] w_thr;
    logic signed [RW-1:0] w_ref_k;
    logic signed [RW-1:0] w_ref_n;
    logic                 w_leg_a;
    logic                 w_leg_b;
    logic [1:0]           r_gate;

    assign w_two_p = {i_p_s, 1'b0};

    // Modular add without a carry bit: both operands are below 2P.
    assign w_room    = w_two_p - i_off;
    assign w_ph_k    = (i_ph >= w_room) ? (i_ph - w_room) : (i_ph + i_off);
    assign w_carrier = (w_ph_k <= {1'b0, i_p_s}) ? w_ph_k : (w_two_p - w_ph_k);

    assign w_p_sgn = $signed({2'b00, i_p_s});
    assign w_thr   = $signed({w_carrier, 1'b0}) - w_p_sgn;

`ifdef CHB_SYNC_UPDATE_EN
    logic signed [RW-1:0] r_ref_k;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ref_k <= '0;
        end else if (i_idle || (w_ph_k == '0)) begin
            r_ref_k <= i_ref_c;
        end
    end

    // The valley output already uses the freshly latched value.
    assign w_ref_k = (w_ph_k == '0) ? i_ref_c : r_ref_k;
`else
    assign w_ref_k = i_ref_c;
`endif

    assign w_ref_n = -w_ref_k;
    assign w_leg_a = (w_ref_k > w_thr) || (w_ref_k == w_p_sgn);
    assign w_leg_b = (w_ref_n > w_thr) || (w_ref_n == w_p_sgn);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_idle) begin
            r_gate <= '0;
        end else begin
            r_gate[LEG_A] <= w_leg_a;
            r_gate[LEG_B] <= w_leg_b;
        end
    end

    assign o_gate = r_gate;

endmodule

// File: rtl/chb_ps_modulator.sv
// rtl/chb_ps_modulator.sv - phase-shifted-carrier PWM top: master counter, shadows, offsets, clamp, sync
// Optional macro CHB_SYNC_UPDATE_EN is consumed by chb_pwm_cell.
module chb_ps_modulator
    import chb_pkg::*;
#(
    parameter int N_CELLS = N_CELLS_DEF,
    parameter int CW      = CW_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [CW-1:0]          i_period,
    input  logic [CW:0]            i_phase_step,
    input  logic signed [CW+1:0]   i_ref,
    output logic [2*N_CELLS-1:0]   o_gate,
    output logic                   o_sync
);

    localparam int PW = phase_width(CW);
    localparam int RW = ref_width(CW);

    logic [CW-1:0]               r_p_s;
    logic [PW-1:0]               r_step_s;
    logic [PW-1:0]               r_ph;
    logic                        r_sync;

    logic [PW-1:0]               w_two_p;
    logic                        w_idle;
    logic                        w_wrap;
    logic [PW-1:0]               w_step_eff;
    logic [PW-1:0]               w_room;
    logic [N_CELLS-1:0][PW-1:0]  w_off;
    logic signed [RW-1:0]        w_p_pos;
    logic signed [RW-1:0]        w_p_neg;
    logic signed [RW-1:0]        w_ref_c;

    assign w_two_p    = {r_p_s, 1'b0};
    assign w_idle     = !i_en || (r_p_s < CW'(2));
    assign w_wrap     = (r_ph == (w_two_p - PW'(1)));
    assign w_step_eff = (r_step_s >= w_two_p) ? '0 : r_step_s;
    assign w_room     = w_two_p - w_step_eff;

    // Shadows only move at the master wrap so no carrier is ever truncated.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p_s    <= '0;
            r_step_s <= '0;
            r_ph     <= '0;
            r_sync   <= 1'b0;
        end else if (w_idle) begin
            r_p_s    <= i_period;
            r_step_s <= i_phase_step;
            r_ph     <= '0;
            r_sync   <= 1'b0;
        end else begin
            r_sync <= (r_ph == '0);
            if (w_wrap) begin
                r_ph     <= '0;
                r_p_s    <= i_period;
                r_step_s <= i_phase_step;
            end else begin
                r_ph <= r_ph + PW'(1);
            end
        end
    end

    assign w_off[0] = '0;

    for (genvar k = 1; k < N_CELLS; k++) begin : g_off
        assign w_off[k] = (w_off[k-1] >= w_room) ? (w_off[k-1] - w_room)
                                                 : (w_off[k-1] + w_step_eff);
    end

    assign w_p_pos = $signed({2'b00, r_p_s});
    assign w_p_neg = -w_p_pos;
    assign w_ref_c = (i_ref > w_p_pos) ? w_p_pos :
                     (i_ref < w_p_neg) ? w_p_neg : i_ref;

    for (genvar k = 0; k < N_CELLS; k++) begin : g_cell
        chb_pwm_cell #(
            .CW (CW)
        ) u_cell (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_ph    (r_ph),
            .i_off   (w_off[k]),
            .i_p_s   (r_p_s),
            .i_ref_c (w_ref_c),
            .i_idle  (w_idle),
            .o_gate  (o_gate[2*k+1:2*k])
        );
    end

    assign o_sync = r_sync;

endmodule
